// File: rtl/cluster_icache_perf_ctrl_if.sv
// Register-bus interface for cluster_icache_perf_ctrl (slave side = the control unit).
// Latency: none, signal bundle only.
// Backpressure: none, the slave ties ready high and completes every request the cycle it is valid.
interface cluster_icache_perf_ctrl_if;
  logic        reg_valid_i;
  logic        reg_write_i;
  logic [9:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;

  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
    output reg_ready_o, reg_rdata_o, reg_error_o
  );

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
    input  reg_ready_o, reg_rdata_o, reg_error_o
  );
endinterface

// File: rtl/cluster_icache_perf_ctrl.sv
// Icache control unit: regbus slave, programmable event counters, per-port flush sequencer.
// Latency: register reads are combinational; writes, counts and flush state take effect next edge.
// Backpressure: none on the register bus; the flush handshake waits on flush_ready_i per port.
// Optional macro ICACHE_PERF_SNAPSHOT_EN adds the 0x14 SNAPSHOT register and shadow-counter reads.
module cluster_icache_perf_ctrl #(
  parameter int NR_FETCH_PORTS = 4,
  parameter int NUM_L0_EVENTS  = 5,
  parameter int NUM_L1_EVENTS  = 7,
  parameter int NUM_COUNTERS   = 8,
  parameter int COUNTER_WIDTH  = 48,
  parameter int FLUSH_TIMEOUT  = 1024
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  cluster_icache_perf_ctrl_if.slave               reg_bus,
  output logic                                    enable_prefetching_o,
  output logic [NR_FETCH_PORTS-1:0]               flush_valid_o,
  input  logic [NR_FETCH_PORTS-1:0]               flush_ready_i,
  input  logic [NR_FETCH_PORTS*NUM_L0_EVENTS-1:0] l0_events_i,
  input  logic [NUM_L1_EVENTS-1:0]                l1_events_i,
  output logic                                    irq_o
);
  localparam int E   = NUM_L1_EVENTS + NR_FETCH_PORTS * NUM_L0_EVENTS;
  localparam int W   = COUNTER_WIDTH;
  localparam int NC  = NUM_COUNTERS;
  localparam int NP  = NR_FETCH_PORTS;
  localparam int TW  = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam int TMO = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, ACTIVE} state_e;

  // Register state
  logic          prefetch_en_q, gcnt_en_q;
  logic [NC-1:0] ovf_q, ovf_d, ovf_set, ovf_w1c, irq_en_q;
  logic [7:0]    evsel_q [NC];
  logic [NC-1:0] en_q, sat_q, cnt_inc;
  logic [W-1:0]  cnt_q [NC];
  logic [W-1:0]  cnt_d [NC];
  logic [W-1:0]  rd_cnt [NC];
  state_e        state_q;
  logic [NP-1:0] pending_q, pend_nxt;
  logic [TW-1:0] timer_q;
  logic          timeout_q, irq_q;

  // Bus decode
  logic [9:0]    addr;
  logic [7:0]    word;
  logic [31:0]   wdata;
  logic          mapped, req_err, wr_en, clear_all, flush_wr;
  logic [31:0]   rd_val;
  logic [NC-1:0] sel_cfg, sel_lo, sel_hi;
  logic [E-1:0]  ev;
  logic [255:0]  ev_pad;

  assign addr  = reg_bus.reg_addr_i;
  assign word  = addr[9:2];
  assign wdata = reg_bus.reg_wdata_i;

  // Padding to 256 makes any evsel >= E select a constant 0.
  assign ev     = {l0_events_i, l1_events_i};
  assign ev_pad = 256'(ev);

  // Address decode and read mux
  always_comb begin
    mapped  = 1'b0;
    rd_val  = '0;
    sel_cfg = '0;
    sel_lo  = '0;
    sel_hi  = '0;
    case (word)
      8'h00: begin mapped = 1'b1; rd_val = {30'b0, gcnt_en_q, prefetch_en_q}; end
      8'h01: begin mapped = 1'b1; rd_val = 32'(pending_q); end
      8'h02: begin mapped = 1'b1; rd_val = {30'b0, timeout_q, state_q == ACTIVE}; end
      8'h03: begin mapped = 1'b1; rd_val = 32'(ovf_q); end
      8'h04: begin mapped = 1'b1; rd_val = 32'(irq_en_q); end
`ifdef ICACHE_PERF_SNAPSHOT_EN
      8'h05: mapped = 1'b1;
`endif
      default: ;
    endcase
    for (int i = 0; i < NC; i++) begin
      if (addr[9:4] == 6'(4 + i)) begin
        case (addr[3:2])
          2'd0: begin mapped = 1'b1; sel_cfg[i] = 1'b1;
                  rd_val = {22'b0, sat_q[i], en_q[i], evsel_q[i]}; end
          2'd1: begin mapped = 1'b1; sel_lo[i] = 1'b1; rd_val = rd_cnt[i][31:0]; end
          2'd2: begin mapped = 1'b1; sel_hi[i] = 1'b1; rd_val = 32'(rd_cnt[i][W-1:32]); end
          default: ;
        endcase
      end
    end
  end

  assign req_err   = reg_bus.reg_valid_i && ((addr[1:0] != 2'b00) || !mapped);
  assign wr_en     = reg_bus.reg_valid_i && reg_bus.reg_write_i && !req_err;
  assign clear_all = wr_en && (word == 8'h00) && wdata[2];
  assign flush_wr  = wr_en && (word == 8'h01) && (wdata[NP-1:0] != '0);
  assign ovf_w1c   = (wr_en && word == 8'h03) ? wdata[NC-1:0] : '0;

  assign reg_bus.reg_ready_o = 1'b1;
  assign reg_bus.reg_error_o = req_err;
  assign reg_bus.reg_rdata_o = (reg_bus.reg_valid_i && !reg_bus.reg_write_i && !req_err) ? rd_val : '0;

  // Counter next-state: clear_all beats a SW write, which beats the increment
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NC; i++) begin
      cnt_inc[i] = gcnt_en_q && en_q[i] && ev_pad[evsel_q[i]];
      cnt_d[i]   = cnt_q[i];
      if (clear_all) begin
        cnt_d[i] = '0;
      end else if (wr_en && sel_lo[i]) begin
        cnt_d[i] = {cnt_q[i][W-1:32], wdata};
      end else if (wr_en && sel_hi[i]) begin
        cnt_d[i] = {wdata[W-33:0], cnt_q[i][31:0]};
      end else if (cnt_inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_set[i] = 1'b1;
          if (!sat_q[i]) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
      end
    end
    // A fresh overflow wins over a same-cycle W1C of that bit.
    ovf_d = clear_all ? '0 : ((ovf_q & ~ovf_w1c) | ovf_set);
  end

  // Control, config, counter and overflow registers; irq is a registered OR of its sources
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prefetch_en_q <= 1'b1;
      gcnt_en_q     <= 1'b0;
      ovf_q         <= '0;
      irq_en_q      <= '0;
      irq_q         <= 1'b0;
      en_q          <= '0;
      sat_q         <= '0;
      for (int i = 0; i < NC; i++) begin
        evsel_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (wr_en && word == 8'h00) begin
        prefetch_en_q <= wdata[0];
        gcnt_en_q     <= wdata[1];
      end
      if (wr_en && word == 8'h04) irq_en_q <= wdata[NC-1:0];
      ovf_q <= ovf_d;
      irq_q <= (|(ovf_q & irq_en_q)) | timeout_q;
      for (int i = 0; i < NC; i++) begin
        if (wr_en && sel_cfg[i]) begin
          evsel_q[i] <= wdata[7:0];
          en_q[i]    <= wdata[8];
          sat_q[i]   <= wdata[9];
        end
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef ICACHE_PERF_SNAPSHOT_EN
  logic [W-1:0] shadow_q [NC];

  // Any write to SNAPSHOT copies every live counter into its shadow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NC; i++) shadow_q[i] <= '0;
    end else if (wr_en && word == 8'h05) begin
      for (int i = 0; i < NC; i++) shadow_q[i] <= cnt_q[i];
    end
  end

  // Counter reads come from the shadow copy
  always_comb begin
    for (int i = 0; i < NC; i++) rd_cnt[i] = shadow_q[i];
  end
`else
  // Counter reads come from the live counters
  always_comb begin
    for (int i = 0; i < NC; i++) rd_cnt[i] = cnt_q[i];
  end
`endif

  // Pending ports drop on their own handshake; new mask bits are merged in
  assign pend_nxt = (pending_q & ~flush_ready_i) | (flush_wr ? wdata[NP-1:0] : '0);

  // Flush sequencer; STATUS.timeout W1C is overridden by a same-edge timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wr_en && word == 8'h02 && wdata[1]) timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_wr) begin
            pending_q <= wdata[NP-1:0];
            timer_q   <= '0;
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pend_nxt == '0) begin
            pending_q <= '0;
            state_q   <= IDLE;
          end else if ((FLUSH_TIMEOUT != 0) && (timer_q == TW'(TMO))) begin
            timeout_q <= 1'b1;
            pending_q <= '0;
            state_q   <= IDLE;
          end else begin
            pending_q <= pend_nxt;
            timer_q   <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enable_prefetching_o = prefetch_en_q;
  assign flush_valid_o        = pending_q;
  assign irq_o                = irq_q;
endmodule

// File: tb/tb_cluster_icache_perf_ctrl.sv
// Scoreboard bench for cluster_icache_perf_ctrl: directed stimulus pushes expected values,
// a negedge monitor pops and compares whenever a read or a signal probe is presented.
module tb_cluster_icache_perf_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_prefetching_o;
  logic [3:0]  flush_valid_o;
  logic [3:0]  flush_ready_i = '0;
  logic [19:0] l0_events_i   = '0;
  logic [6:0]  l1_events_i   = '0;
  logic        irq_o;

  cluster_icache_perf_ctrl_if bus();

  cluster_icache_perf_ctrl #(
    .NR_FETCH_PORTS(4), .NUM_L0_EVENTS(5), .NUM_L1_EVENTS(7),
    .NUM_COUNTERS(8), .COUNTER_WIDTH(48), .FLUSH_TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg_bus(bus),
    .enable_prefetching_o(enable_prefetching_o),
    .flush_valid_o(flush_valid_o), .flush_ready_i(flush_ready_i),
    .l0_events_i(l0_events_i), .l1_events_i(l1_events_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [33:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [33:0] act;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        probe_en   = 1'b0;
  int          probe_kind = 0;

  // Monitor: reads compare {ready, error, rdata}; probes compare a single output
  always @(negedge clk_i) begin
    if (!rst_i && ((bus.reg_valid_i && !bus.reg_write_i) || probe_en)) begin
      if (probe_en) begin
        case (probe_kind)
          0:       act = 34'(irq_o);
          1:       act = 34'(flush_valid_o);
          default: act = 34'(enable_prefetching_o);
        endcase
      end else begin
        act = {bus.reg_ready_o, bus.reg_error_o, bus.reg_rdata_o};
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      end else begin
        cur = exp_q.pop_front();
        if (act !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.reg_valid_i = 1'b1; bus.reg_write_i = 1'b1;
    bus.reg_addr_i  = a;    bus.reg_wdata_i = d;
    tick(1);
    bus.reg_valid_i = 1'b0; bus.reg_write_i = 1'b0;
  endtask

  task automatic rd_chk(input logic [9:0] a, input logic [31:0] e, input logic err, input string nm);
    exp_t x;
    x.name = nm; x.exp = {1'b1, err, e};
    exp_q.push_back(x);
    bus.reg_valid_i = 1'b1; bus.reg_write_i = 1'b0; bus.reg_addr_i = a;
    tick(1);
    bus.reg_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input string nm);
    rd_chk(a, e, 1'b0, nm);
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string nm);
    exp_t x;
    x.name = nm; x.exp = 34'(e);
    exp_q.push_back(x);
    probe_kind = k; probe_en = 1'b1;
    tick(1);
    probe_en = 1'b0;
  endtask

  task automatic pulse_l1(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      l1_events_i[b] = 1'b1; tick(1); l1_events_i = '0; tick(1);
    end
  endtask

  task automatic pulse_l0(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      l0_events_i[b] = 1'b1; tick(1); l0_events_i = '0; tick(1);
    end
  endtask

  initial begin
    bus.reg_valid_i = 1'b0; bus.reg_write_i = 1'b0;
    bus.reg_addr_i  = '0;   bus.reg_wdata_i = '0;
    tick(3);
    rst_i = 1'b0;
    tick(1);

    // Reset state and decode errors
    rd(10'h000, 32'h1, "rst_ctrl");
    probe(2, 1, "rst_prefetch");
    probe(0, 0, "rst_irq");
    probe(1, 0, "rst_flush_valid");
    rd(10'h008, 32'h0, "rst_status");
    rd(10'h00C, 32'h0, "rst_ovf");
    rd(10'h044, 32'h0, "rst_cnt0_lo");
    rd_chk(10'h014, 32'h0, 1'b1, "snapshot_unmapped");
    rd_chk(10'h002, 32'h0, 1'b1, "misaligned");
    rd_chk(10'h04C, 32'h0, 1'b1, "cfg_gap_unmapped");
    rd_chk(10'h0C0, 32'h0, 1'b1, "counter8_unmapped");

    // Basic counting: 10 L1 event-0 pulses
    wr(10'h040, 32'h100);
    wr(10'h000, 32'h3);
    pulse_l1(0, 10);
    rd(10'h044, 32'd10, "cnt0_lo_10");
    rd(10'h048, 32'h0, "cnt0_hi_0");
    rd(10'h040, 32'h100, "cfg0_readback");
    rd(10'h000, 32'h3, "ctrl_readback");

    // Wrap at all-ones, bits above the width read 0, overflow + irq
    wr(10'h054, 32'hFFFF_FFFF);
    wr(10'h058, 32'hFFFF_FFFF);
    rd(10'h058, 32'h0000_FFFF, "cnt1_hi_width_mask");
    wr(10'h050, 32'h101);
    pulse_l1(1, 1);
    rd(10'h054, 32'h0, "wrap_cnt1_lo");
    rd(10'h058, 32'h0, "wrap_cnt1_hi");
    rd(10'h00C, 32'h2, "wrap_ovf");
    probe(0, 0, "irq_masked");
    wr(10'h010, 32'h2);
    tick(1);
    probe(0, 1, "irq_on_ovf");
    wr(10'h00C, 32'h2);
    tick(1);
    probe(0, 0, "irq_after_w1c");
    rd(10'h00C, 32'h0, "ovf_w1c");

    // Saturate at all-ones
    wr(10'h050, 32'h301);
    wr(10'h054, 32'hFFFF_FFFF);
    wr(10'h058, 32'h0000_FFFF);
    pulse_l1(1, 1);
    rd(10'h054, 32'hFFFF_FFFF, "sat_cnt1_lo");
    rd(10'h058, 32'h0000_FFFF, "sat_cnt1_hi");
    rd(10'h00C, 32'h2, "sat_ovf");
    tick(1);
    probe(0, 1, "sat_irq");
    wr(10'h00C, 32'h2);
    tick(1);
    probe(0, 0, "sat_irq_drop");
    rd(10'h00C, 32'h0, "sat_ovf_w1c");

    // W1C loses to a same-cycle overflow; SW write beats increment
    l1_events_i[1] = 1'b1;
    wr(10'h00C, 32'h2);
    l1_events_i = '0;
    rd(10'h00C, 32'h2, "ovf_w1c_vs_set");
    wr(10'h00C, 32'h2);
    l1_events_i[0] = 1'b1;
    wr(10'h044, 32'd5);
    l1_events_i = '0;
    rd(10'h044, 32'd5, "sw_write_beats_inc");

    // evsel = E (27) never counts, evsel = E-1 (port3 L0 ev4, bit 19) counts
    wr(10'h060, 32'h11B);
    wr(10'h070, 32'h11A);
    l1_events_i = '1; l0_events_i = '1;
    tick(1);
    l1_events_i = '0; l0_events_i = '0;
    pulse_l0(19, 2);
    pulse_l0(18, 1);
    rd(10'h064, 32'h0, "evsel_out_of_range");
    rd(10'h074, 32'd3, "evsel_last");
    rd(10'h044, 32'd6, "cnt0_all_events");

    // clear_all in the same cycle as an active event
    l1_events_i[0] = 1'b1;
    wr(10'h000, 32'h7);
    l1_events_i = '0;
    rd(10'h044, 32'h0, "clr_cnt0");
    rd(10'h054, 32'h0, "clr_cnt1_lo");
    rd(10'h058, 32'h0, "clr_cnt1_hi");
    rd(10'h074, 32'h0, "clr_cnt3");
    rd(10'h00C, 32'h0, "clr_ovf");
    rd(10'h000, 32'h3, "clr_reads_zero");
    rd(10'h070, 32'h11A, "clr_cfg_kept");
    pulse_l0(19, 1);
    rd(10'h074, 32'd1, "evsel_last_after_clr");

    // Global count enable off, prefetch bit
    wr(10'h000, 32'h0);
    probe(2, 0, "prefetch_off");
    pulse_l1(0, 1);
    rd(10'h044, 32'h0, "global_disable");
    wr(10'h000, 32'h1);
    probe(2, 1, "prefetch_on");

    // Flush: mask 0 is a no-op, then 0x5 acked port by port
    wr(10'h004, 32'h0);
    rd(10'h008, 32'h0, "flush_mask0_noop");
    wr(10'h004, 32'h5);
    probe(1, 32'h5, "flush_valid_5");
    rd(10'h008, 32'h1, "flush_busy");
    rd(10'h004, 32'h5, "flush_pending_5");
    flush_ready_i = 4'h1; tick(1); flush_ready_i = '0;
    probe(1, 32'h4, "flush_valid_4");
    rd(10'h008, 32'h1, "flush_busy_2");
    tick(1);
    flush_ready_i = 4'h4; tick(1); flush_ready_i = '0;
    probe(1, 32'h0, "flush_valid_0");
    rd(10'h008, 32'h0, "flush_idle");

    // Write while active merges into pending
    wr(10'h004, 32'h1);
    wr(10'h004, 32'h2);
    rd(10'h004, 32'h3, "flush_or_pending");
    probe(1, 32'h3, "flush_or_valid");
    flush_ready_i = 4'h3; tick(1); flush_ready_i = '0;
    tick(1);
    rd(10'h008, 32'h0, "flush_or_idle");

    // Timeout after 16 active cycles, late ack ignored
    wr(10'h004, 32'h1);
    tick(10);
    rd(10'h008, 32'h1, "tmo_still_busy");
    probe(1, 32'h1, "tmo_valid_held");
    tick(8);
    rd(10'h008, 32'h2, "tmo_status");
    probe(1, 32'h0, "tmo_valid_dropped");
    probe(0, 1, "tmo_irq");
    flush_ready_i = 4'h1; tick(1); flush_ready_i = '0;
    rd(10'h008, 32'h2, "tmo_late_ack");
    rd(10'h004, 32'h0, "tmo_pending_0");
    wr(10'h008, 32'h2);
    tick(1);
    probe(0, 0, "tmo_irq_clear");
    rd(10'h008, 32'h0, "tmo_w1c");

    tick(2);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
